// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared opcodes, flag indices and FSM encoding for alu_arbiter
//
// Contents:
//   OP_*      4-bit ALU opcodes
//   FLG_*     bit positions inside the 4-bit {P,V,C,Z} flag word
//   state_e   arbiter FSM state encoding
//   parity4   XOR-reduction helper used for the P flag
package alu_arb_pkg;

  localparam logic [3:0] OP_SHL     = 4'h0;
  localparam logic [3:0] OP_SHL_ALT = 4'h1;
  localparam logic [3:0] OP_SHR     = 4'h2;
  localparam logic [3:0] OP_SHRK    = 4'h3;
  localparam logic [3:0] OP_ADD     = 4'h4;
  localparam logic [3:0] OP_INC     = 4'h5;
  localparam logic [3:0] OP_SUB     = 4'h6;
  localparam logic [3:0] OP_DEC     = 4'h7;
  localparam logic [3:0] OP_AND     = 4'h8;
  localparam logic [3:0] OP_OR      = 4'h9;
  localparam logic [3:0] OP_XOR     = 4'hA;
  localparam logic [3:0] OP_NOR     = 4'hB;
  localparam logic [3:0] OP_EQ      = 4'hC;
  localparam logic [3:0] OP_NE      = 4'hD;
  localparam logic [3:0] OP_SGT     = 4'hE;
  localparam logic [3:0] OP_SLT     = 4'hF;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_V = 2;
  localparam int FLG_P = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic parity4(input logic [3:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/alu4_core.sv
// rtl/alu4_core.sv - purely combinational 4-bit ALU shared by all requesters
//
// Ports:
//   a_i      operand A
//   b_i      operand B
//   op_i     opcode (see alu_arb_pkg OP_*)
//   out_o    4-bit result
//   flags_o  {P,V,C,Z}; C and V are only meaningful for the add/sub group
module alu4_core
  import alu_arb_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] op_i,
  output logic [3:0] out_o,
  output logic [3:0] flags_o
);

  logic [3:0] addend;
  logic       cin;
  logic [4:0] sum;
  logic       arith;
  logic       c3;
  logic       c4;
  logic [3:0] res;

  always_comb begin
    addend = b_i;
    cin    = 1'b0;
    res    = '0;
    // Opcodes 4..7 form the adder group; subtraction reuses the adder as A+~B+1.
    arith  = (op_i[3:2] == 2'b01);

    unique case (op_i)
      OP_INC:  addend = 4'd1;
      OP_SUB:  begin addend = ~b_i;  cin = 1'b1; end
      OP_DEC:  begin addend = ~4'd1; cin = 1'b1; end
      default: addend = b_i;
    endcase

    sum = {1'b0, a_i} + {1'b0, addend} + {4'd0, cin};
    c4  = sum[4];
    // Carry into bit 3 recovered from the bit-3 sum: s3 = a3 ^ b3 ^ c3.
    c3  = sum[3] ^ a_i[3] ^ addend[3];

    unique case (op_i)
      OP_SHL, OP_SHL_ALT: res = b_i << a_i[1:0];
      OP_SHR:             res = b_i >> a_i[1:0];
      OP_SHRK:            res = {b_i[3], 3'(b_i >> a_i[1:0])};
      OP_ADD, OP_INC,
      OP_SUB, OP_DEC:     res = sum[3:0];
      OP_AND:             res = a_i & b_i;
      OP_OR:              res = a_i | b_i;
      OP_XOR:             res = a_i ^ b_i;
      OP_NOR:             res = ~(a_i | b_i);
      OP_EQ:              res = {3'd0, (a_i == b_i)};
      OP_NE:              res = {3'd0, (a_i != b_i)};
      OP_SGT:             res = {3'd0, ($signed(a_i) > $signed(b_i))};
      OP_SLT:             res = {3'd0, ($signed(a_i) < $signed(b_i))};
      default:            res = '0;
    endcase

    out_o          = res;
    flags_o        = '0;
    flags_o[FLG_Z] = (res == 4'd0);
    flags_o[FLG_C] = arith & c4;
    flags_o[FLG_V] = arith & (c3 ^ c4);
    flags_o[FLG_P] = parity4(res);
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one 4-bit ALU between NREQ requesters
//
// Configuration macro: ALU_ARB_FIXED_PRIO_EN (defined: fixed priority, lowest index wins,
// no round-robin pointer; undefined: round-robin).
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   req_valid    per-requester request valid
//   req_ready    per-requester accept, one-hot or zero, only in IDLE
//   req_a/b/op   packed 4-bit fields, requester i at [4i+3:4i]
//   resp_valid   response valid (held in RESP until resp_ready)
//   resp_ready   response consumer ready
//   resp_id      index of the requester served
//   resp_out     ALU result
//   resp_flags   {P,V,C,Z}
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  input  logic [4*NREQ-1:0] req_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [3:0]        resp_out,
  output logic [3:0]        resp_flags
);

  state_e state_q, state_d;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] hi_idx, lo_idx;
  logic           hi_found, lo_found;
  logic           accept;

  logic [3:0]     sel_a, sel_b, sel_op;
  logic [3:0]     a_q, b_q, op_q;
  logic [IDW-1:0] id_q;

  logic [3:0]     core_out, core_flags;
  logic [3:0]     resp_out_q, resp_flags_q;
  logic [IDW-1:0] resp_id_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  assign rr_ptr = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Cyclic search from rr_ptr: prefer the lowest valid index >= rr_ptr, otherwise
  // wrap around to the lowest valid index overall. Loops run downward so the last
  // hit (lowest index) wins.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
        if (IDW'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    grant = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_a  = req_a[4*i +: 4];
        sel_b  = req_b[4*i +: 4];
        sel_op = req_op[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Held off while rst is high so the ready outputs read as 0 during reset.
        if (lo_found && !rst) begin
          for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (grant == IDW'(i));
          end
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  alu4_core u_core (
    .a_i     (a_q),
    .b_i     (b_q),
    .op_i    (op_q),
    .out_o   (core_out),
    .flags_o (core_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= '0;
      resp_out_q   <= '0;
      resp_flags_q <= '0;
      resp_id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q  <= sel_a;
        b_q  <= sel_b;
        op_q <= sel_op;
        id_q <= grant;
      end
      // Response registers load only in EXEC, so they stay frozen through RESP.
      if (state_q == ST_EXEC) begin
        resp_out_q   <= core_out;
        resp_flags_q <= core_flags;
        resp_id_q    <= id_q;
      end
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_out   = resp_out_q;
  assign resp_flags = resp_flags_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a, req_b, req_op;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [3:0]        resp_out;
  logic [3:0]        resp_flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_out   (resp_out),
    .resp_flags (resp_flags)
  );

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [3:0] out;
    logic [3:0] flg;
  } vec_t;

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Presents one request on requester idx from a negedge, drops valid after the
  // accept edge and waits (bounded) for resp_valid. lat counts edges after accept.
  task automatic issue(input int idx, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, output int lat, output logic [NREQ-1:0] rdy);
    @(negedge clk);
    req_a = '0; req_b = '0; req_op = '0;
    req_a[4*idx +: 4]  = a;
    req_b[4*idx +: 4]  = b;
    req_op[4*idx +: 4] = op;
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    resp_ready     = 1'b0;
    #1 rdy = req_ready;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) req_valid = '0;
    end while (resp_valid !== 1'b1 && lat < 12);
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = '1;
    req_a      = '0; req_b = '0; req_op = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready actual=%b required=00", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid actual=%b required=0", resp_valid); end
    n_checks++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL reset_resp_id actual=%0d required=0", resp_id); end
    n_checks++; if (resp_out !== 4'h0) begin n_fail++; $display("FAIL reset_resp_out actual=%h required=0", resp_out); end
    n_checks++; if (resp_flags !== 4'h0) begin n_fail++; $display("FAIL reset_resp_flags actual=%b required=0000", resp_flags); end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL idle_no_valid_ready actual=%b required=00", req_ready); end
  endtask

  task automatic test_alu_ops();
    vec_t v[19];
    int lat;
    logic [NREQ-1:0] rdy;
    logic [NREQ-1:0] exp_rdy;
    //          idx    a      b      op     out    {P,V,C,Z}
    v[0]  = '{2'd0, 4'h5, 4'h3, 4'h4, 4'h8, 4'b1100};
    v[1]  = '{2'd1, 4'h3, 4'h3, 4'h6, 4'h0, 4'b0011};
    v[2]  = '{2'd0, 4'h2, 4'h3, 4'h0, 4'hC, 4'b0000};
    v[3]  = '{2'd0, 4'h1, 4'hF, 4'hE, 4'h1, 4'b1000};
    v[4]  = '{2'd1, 4'h1, 4'h8, 4'h3, 4'hC, 4'b0000};
    v[5]  = '{2'd0, 4'h0, 4'h5, 4'h7, 4'hF, 4'b0000};
    v[6]  = '{2'd1, 4'h8, 4'h7, 4'hF, 4'h1, 4'b1000};
    v[7]  = '{2'd0, 4'hA, 4'h5, 4'hB, 4'h0, 4'b0001};
    v[8]  = '{2'd1, 4'h7, 4'h2, 4'h5, 4'h8, 4'b1100};
    v[9]  = '{2'd0, 4'hC, 4'hA, 4'h8, 4'h8, 4'b1000};
    v[10] = '{2'd1, 4'hF, 4'hF, 4'hA, 4'h0, 4'b0001};
    v[11] = '{2'd0, 4'h3, 4'h8, 4'h2, 4'h1, 4'b1000};
    v[12] = '{2'd1, 4'h6, 4'h6, 4'hC, 4'h1, 4'b1000};
    v[13] = '{2'd0, 4'h6, 4'h6, 4'hD, 4'h0, 4'b0001};
    v[14] = '{2'd1, 4'h7, 4'h8, 4'hE, 4'h1, 4'b1000};
    v[15] = '{2'd0, 4'h3, 4'h4, 4'h9, 4'h7, 4'b1000};
    v[16] = '{2'd1, 4'hF, 4'h1, 4'h4, 4'h0, 4'b0011};
    v[17] = '{2'd0, 4'h0, 4'h1, 4'h6, 4'hF, 4'b0000};
    v[18] = '{2'd1, 4'h3, 4'h1, 4'h1, 4'h8, 4'b1000};
    do_reset();
    for (int k = 0; k < 19; k++) begin
      issue(int'(v[k].idx), v[k].a, v[k].b, v[k].op, lat, rdy);
      exp_rdy = '0;
      exp_rdy[v[k].idx] = 1'b1;
      n_checks++; if (rdy !== exp_rdy) begin n_fail++; $display("FAIL op%0d_req_ready actual=%b required=%b", k, rdy, exp_rdy); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL op%0d_latency actual=%0d required=2", k, lat); end
      n_checks++; if (resp_id !== v[k].idx) begin n_fail++; $display("FAIL op%0d_resp_id actual=%0d required=%0d", k, resp_id, v[k].idx); end
      n_checks++; if (resp_out !== v[k].out) begin n_fail++; $display("FAIL op%0d_resp_out actual=%h required=%h", k, resp_out, v[k].out); end
      n_checks++; if (resp_flags !== v[k].flg) begin n_fail++; $display("FAIL op%0d_resp_flags actual=%b required=%b", k, resp_flags, v[k].flg); end
      finish_resp();
    end
  endtask

  task automatic test_back_to_back();
    int grants[4];
    int gcyc[4];
    int ng;
    int exp_g[4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    do_reset();
    req_a  = 8'h35; req_b = 8'h12; req_op = 8'h44;
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 30 && ng < 4; c++) begin
      #1;
      if (req_ready == 2'b01) begin grants[ng] = 0; gcyc[ng] = c; ng++; end
      else if (req_ready == 2'b10) begin grants[ng] = 1; gcyc[ng] = c; ng++; end
      @(negedge clk);
    end
    req_valid  = '0;
    resp_ready = 1'b0;
    n_checks++; if (ng !== 4) begin n_fail++; $display("FAIL rr_grant_count actual=%0d required=4", ng); end
    for (int k = 0; k < ng; k++) begin
      n_checks++; if (grants[k] !== exp_g[k]) begin n_fail++; $display("FAIL rr_grant%0d actual=%0d required=%0d", k, grants[k], exp_g[k]); end
    end
    if (ng >= 2) begin
      n_checks++; if (gcyc[1] - gcyc[0] !== 3) begin n_fail++; $display("FAIL rr_throughput actual=%0d required=3", gcyc[1] - gcyc[0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] exp_next;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_next = 2'b01;
`else
    exp_next = 2'b10;
`endif
    do_reset();
    @(negedge clk);
    req_a = 8'h75; req_b = 8'h33; req_op = 8'h44;
    req_valid  = 2'b01;
    resp_ready = 1'b0;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_accept_ready actual=%b required=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_exec_ready actual=%b required=00", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_exec_valid actual=%b required=0", resp_valid); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d_valid actual=%b required=1", c, resp_valid); end
      n_checks++; if (resp_out !== 4'h8 || resp_flags !== 4'b1100 || resp_id !== 2'd0)
        begin n_fail++; $display("FAIL bp_hold%0d_resp actual=%h/%b/%0d required=8/1100/0", c, resp_out, resp_flags, resp_id); end
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_hold%0d_ready actual=%b required=00", c, req_ready); end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after_valid actual=%b required=0", resp_valid); end
    n_checks++; if (req_ready !== exp_next) begin n_fail++; $display("FAIL bp_next_accept actual=%b required=%b", req_ready, exp_next); end
    req_valid = '0;
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    @(negedge clk);
    req_a = 8'h05; req_b = 8'h03; req_op = 8'h44;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL rstexec_ctrl actual=%b/%b required=0/00", resp_valid, req_ready); end
    n_checks++; if (resp_out !== 4'h0 || resp_flags !== 4'h0 || resp_id !== 2'd0)
      begin n_fail++; $display("FAIL rstexec_data actual=%h/%b/%0d required=0/0000/0", resp_out, resp_flags, resp_id); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstexec_quiet%0d actual=%b required=0", c, resp_valid); end
    end
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstexec_ptr actual=%b required=01", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_in_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
